// File: rtl/ahb_lite_master_mc.sv
// Pipelined multi-channel AHB-Lite master: fixed-priority grant, overlapped A/D phases, two-cycle ERROR recovery.
// Optional perf counters (xfer_cnt, wait_cnt) when AHB_MASTER_PERF_EN is defined.
module ahb_lite_master_mc #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_CH   = 2,
    parameter int FETCH_CH = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              req_valid,
    output logic [NUM_CH-1:0]              req_ready,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_CH-1:0]              req_write,
    input  logic [NUM_CH-1:0][2:0]         req_size,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  req_wdata,
    output logic [NUM_CH-1:0]              rsp_valid,
    output logic [DATA_W-1:0]              rsp_rdata,
    output logic                           rsp_err,
    output logic [ADDR_W-1:0]              haddr,
    output logic [1:0]                     htrans,
    output logic                           hwrite,
    output logic [2:0]                     hsize,
    output logic [3:0]                     hprot,
    output logic [DATA_W-1:0]              hwdata,
    input  logic                           hready,
    input  logic                           hresp,
    input  logic [DATA_W-1:0]              hr_data
`ifdef AHB_MASTER_PERF_EN
    ,
    output logic [31:0]                    xfer_cnt,
    output logic [31:0]                    wait_cnt
`endif
);
    localparam int LB = $clog2(DATA_W / 8);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {RUN, ERR1, ERR2} state_t;

    typedef struct packed {
        logic [CW-1:0]     ch;
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [2:0]        size;
        logic [DATA_W-1:0] wdata;
        logic              lerr;
    } a_slot_t;

    typedef struct packed {
        logic [CW-1:0]     ch;
        logic              write;
        logic [2:0]        size;
        logic [LB-1:0]     lo;
        logic [DATA_W-1:0] wdata;
        logic              lerr;
    } d_slot_t;

    function automatic logic is_lerr(input logic [7:0] addr, input logic [2:0] size);
        logic [7:0] amask;
        if (size[2] || int'(size) > LB) return 1'b1;
        amask = (8'd1 << size) - 8'd1;
        return (addr & amask) != 8'd0;
    endfunction

    // Narrow write data is copied into every lane of its size.
    function automatic logic [DATA_W-1:0] lane_rep(input logic [DATA_W-1:0] d, input logic [2:0] size);
        logic [DATA_W-1:0] r;
        int n;
        n = 1 << ((int'(size) > LB) ? LB : int'(size));
        r = '0;
        for (int i = 0; i < DATA_W / 8; i++) r[i*8 +: 8] = d[(i % n)*8 +: 8];
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] lane_ext(input logic [DATA_W-1:0] d, input logic [LB-1:0] lo,
                                                   input logic [2:0] size);
        logic [DATA_W-1:0] s, m;
        s = d >> {lo, 3'b000};
        m = '0;
        for (int i = 0; i < DATA_W / 8; i++) if (i < (1 << int'(size))) m[i*8 +: 8] = 8'hFF;
        return s & m;
    endfunction

    state_t                         state;
    logic [1:0]                     vld_pipe;   // [0] = A slot, [1] = D slot
    a_slot_t                        a, a_nxt;
    d_slot_t                        d;
    logic [NUM_CH-1:0]              ch_lerr;
    logic [NUM_CH-1:0][DATA_W-1:0]  ch_wrep;
    logic [CW-1:0]                  gnt;
    logic                           gnt_vld, adv, acc;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_lerr[c] = is_lerr(req_addr[c][7:0], req_size[c]);
        assign ch_wrep[c] = lane_rep(req_wdata[c], req_size[c]);
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (req_valid[c]) begin
                gnt_vld = 1'b1;
                gnt     = CW'(c);
            end
        end
    end

    assign adv       = hready && (state != ERR1);
    assign acc       = adv && gnt_vld;
    assign req_ready = (adv && reset && gnt_vld) ? (NUM_CH'(1) << gnt) : '0;

    always_comb begin
        a_nxt = '{ch: gnt, addr: req_addr[gnt], write: req_write[gnt], size: req_size[gnt],
                  wdata: ch_wrep[gnt], lerr: ch_lerr[gnt]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            vld_pipe  <= '0;
            a         <= '0;
            d         <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (vld_pipe[1] && hready) begin
                rsp_valid[d.ch] <= 1'b1;
                rsp_err         <= hresp | d.lerr;
                rsp_rdata       <= d.write ? '0 : lane_ext(hr_data, d.lo, d.size);
            end
            if (adv) begin
                vld_pipe[1] <= vld_pipe[0];
                d           <= '{ch: a.ch, write: a.write, size: a.size, lo: a.addr[LB-1:0],
                                 wdata: a.wdata, lerr: a.lerr};
                vld_pipe[0] <= acc;
                if (acc) a <= a_nxt;
            end
            case (state)
                RUN:  if (!hready && hresp && vld_pipe[1]) state <= ERR1;
                // Second ERROR cycle: D retires, A stays put to be reissued from ERR2.
                ERR1: if (hready) begin
                    vld_pipe[1] <= 1'b0;
                    state       <= ERR2;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign htrans = (vld_pipe[0] && !a.lerr && state != ERR1) ? 2'b10 : 2'b00;
    assign haddr  = vld_pipe[0] ? a.addr : '0;
    assign hwrite = vld_pipe[0] && a.write;
    assign hsize  = vld_pipe[0] ? a.size : 3'b000;
    assign hprot  = !vld_pipe[0] ? 4'b0000 : (a.ch == CW'(FETCH_CH)) ? 4'b0010 : 4'b0011;
    assign hwdata = (vld_pipe[1] && d.write) ? d.wdata : '0;

`ifdef AHB_MASTER_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            xfer_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            if (vld_pipe[1] && hready && !d.lerr && xfer_cnt != '1) xfer_cnt <= xfer_cnt + 32'd1;
            if (vld_pipe[1] && !hready && wait_cnt != '1) wait_cnt <= wait_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ahb_lite_master_mc.sv
// Directed bench for ahb_lite_master_mc: grant, pipelining, lanes, wait states, ERROR recovery, reset.
module tb_ahb_lite_master_mc;
    logic             clk, reset;
    logic [1:0]       req_valid, req_ready, req_write;
    logic [1:0][31:0] req_addr, req_wdata;
    logic [1:0][2:0]  req_size;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_rdata, haddr, hwdata, hr_data;
    logic             rsp_err, hwrite, hready, hresp;
    logic [1:0]       htrans;
    logic [2:0]       hsize;
    logic [3:0]       hprot;
`ifdef AHB_MASTER_PERF_EN
    logic [31:0]      xfer_cnt, wait_cnt;
`endif
    int n_chk = 0, n_fail = 0;

    ahb_lite_master_mc dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready), .hresp(hresp), .hr_data(hr_data)
`ifdef AHB_MASTER_PERF_EN
        , .xfer_cnt(xfer_cnt), .wait_cnt(wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input int ch, input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] wd);
        req_valid       = '0;
        req_valid[ch]   = 1'b1;
        req_addr[ch]    = addr;
        req_write[ch]   = wr;
        req_size[ch]    = sz;
        req_wdata[ch]   = wd;
    endtask

    task automatic lerr_case(input int ch, input logic [31:0] addr, input logic [2:0] sz);
        logic [1:0] exp_v;
        exp_v = 2'b00;
        exp_v[ch] = 1'b1;
        req(ch, addr, 1'b0, sz, 32'h0);
        #1 chk("lerr_ready", req_ready, exp_v);
        cyc(); req_valid = '0;
        chk("lerr_idle1", htrans, 2'b00);
        cyc(); chk("lerr_idle2", htrans, 2'b00);
        cyc(); chk("lerr_rsp", rsp_valid, exp_v); chk("lerr_err", rsp_err, 1'b1);
        cyc(); chk("lerr_quiet", rsp_valid, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; req_valid = '0; req_addr = '0; req_write = '0; req_size = '0; req_wdata = '0;
        hready = 1'b1; hresp = 1'b0; hr_data = 32'h0;
        cyc(); cyc();
        req_valid = 2'b11;
        #1 chk("rst_ready", req_ready, 2'b00);
        chk("rst_htrans", htrans, 2'b00); chk("rst_haddr", haddr, 0); chk("rst_hprot", hprot, 0);
        chk("rst_hsize", hsize, 0); chk("rst_hwrite", hwrite, 0); chk("rst_hwdata", hwdata, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        req_valid = '0;
        reset = 1'b1;
        cyc();

        // zero-wait fetch read
        req(0, 32'h100, 1'b0, 3'd2, 32'h0);
        #1 chk("zw_ready", req_ready, 2'b01);
        cyc(); req_valid = '0;
        chk("zw_htrans", htrans, 2'b10); chk("zw_haddr", haddr, 32'h100); chk("zw_hprot", hprot, 4'b0010);
        cyc(); hr_data = 32'hDEADBEEF;
        chk("zw_early", rsp_valid, 2'b00);
        cyc();
        chk("zw_rsp", rsp_valid, 2'b01); chk("zw_rdata", rsp_rdata, 32'hDEADBEEF); chk("zw_err", rsp_err, 0);
        cyc(); chk("zw_pulse", rsp_valid, 2'b00);

        // back-to-back write then read on ch1
        req(1, 32'h200, 1'b1, 3'd2, 32'h11223344);
        #1 chk("b2b_ready0", req_ready, 2'b10);
        cyc();
        chk("b2b_haddr0", haddr, 32'h200); chk("b2b_hwrite0", hwrite, 1'b1); chk("b2b_hprot", hprot, 4'b0011);
        req(1, 32'h204, 1'b0, 3'd2, 32'h0);
        #1 chk("b2b_ready1", req_ready, 2'b10);
        cyc(); req_valid = '0;
        chk("b2b_haddr1", haddr, 32'h204); chk("b2b_hwdata", hwdata, 32'h11223344); chk("b2b_hwrite1", hwrite, 0);
        cyc(); hr_data = 32'hCAFEF00D;
        chk("b2b_rsp0", rsp_valid, 2'b10); chk("b2b_wr_rdata", rsp_rdata, 0);
        cyc();
        chk("b2b_rsp1", rsp_valid, 2'b10); chk("b2b_rdata", rsp_rdata, 32'hCAFEF00D);
        cyc(); chk("b2b_quiet", rsp_valid, 2'b00);

        // contention: ch1 first, ch0 on the next edge
        req_valid = 2'b11; req_write = 2'b00; req_size = {3'd2, 3'd2};
        req_addr[1] = 32'h10; req_addr[0] = 32'h20;
        #1 chk("arb_ready0", req_ready, 2'b10);
        cyc(); req_valid = 2'b01;
        #1 chk("arb_ready1", req_ready, 2'b01); chk("arb_haddr0", haddr, 32'h10);
        cyc(); req_valid = '0;
        chk("arb_haddr1", haddr, 32'h20); chk("arb_hprot1", hprot, 4'b0010);
        cyc(); chk("arb_rsp0", rsp_valid, 2'b10);
        cyc(); chk("arb_rsp1", rsp_valid, 2'b01);
        cyc();

        // byte lanes: write byte replication, read byte extraction
        req(1, 32'h103, 1'b1, 3'd0, 32'h000000AB);
        cyc(); req(1, 32'h102, 1'b0, 3'd0, 32'h0);
        cyc(); req_valid = '0;
        chk("lane_hwdata", hwdata, 32'hABABABAB); chk("lane_hsize", hsize, 3'd0);
        cyc(); hr_data = 32'h12345678;
        cyc(); chk("lane_rdata", rsp_rdata, 32'h34);
        cyc();

        // wait states
        req(1, 32'h40, 1'b1, 3'd2, 32'hA5A50001);
        cyc(); req(1, 32'h48, 1'b0, 3'd2, 32'h0);
        cyc(); req_valid = '0; hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ws_htrans", htrans, 2'b10); chk("ws_haddr", haddr, 32'h48);
            chk("ws_hwdata", hwdata, 32'hA5A50001); chk("ws_rsp", rsp_valid, 2'b00);
            cyc();
        end
        hready = 1'b1;
        cyc(); hr_data = 32'h0BADF00D;
        chk("ws_rsp0", rsp_valid, 2'b10); chk("ws_err0", rsp_err, 0);
`ifdef AHB_MASTER_PERF_EN
        chk("ws_wait_cnt", wait_cnt, 3);
`endif
        cyc(); chk("ws_rsp1", rsp_valid, 2'b10); chk("ws_rdata", rsp_rdata, 32'h0BADF00D);
        cyc();

        // ERROR with pipelined read of 0x300 held in A
        req(1, 32'h2F0, 1'b0, 3'd2, 32'h0);
        cyc(); req(1, 32'h300, 1'b0, 3'd2, 32'h0);
        cyc(); req_valid = '0; hresp = 1'b1; hready = 1'b0;
        cyc();
        chk("err1_htrans", htrans, 2'b00); chk("err1_rsp", rsp_valid, 2'b00);
        hready = 1'b1; req(0, 32'h0, 1'b0, 3'd2, 32'h0);
        #1 chk("err1_ready", req_ready, 2'b00);
        req_valid = '0;
        cyc(); hresp = 1'b0;
        chk("err_rsp", rsp_valid, 2'b10); chk("err_rsp_err", rsp_err, 1'b1);
        chk("err2_htrans", htrans, 2'b10); chk("err2_haddr", haddr, 32'h300);
        cyc(); hr_data = 32'h33333333;
        chk("err_gap", rsp_valid, 2'b00);
        cyc();
        chk("reis_rsp", rsp_valid, 2'b10); chk("reis_err", rsp_err, 0); chk("reis_rdata", rsp_rdata, 32'h33333333);
        cyc();

        // local errors: misaligned halfword, oversize doubleword
        lerr_case(0, 32'h101, 3'd1);
        lerr_case(1, 32'h0, 3'd3);

        // reset in mid-transfer
        req(1, 32'h500, 1'b1, 3'd2, 32'h55);
        cyc(); req(1, 32'h504, 1'b0, 3'd2, 32'h0);
        cyc(); req_valid = '0; hr_data = 32'hFFFFFFFF;
        chk("mr_hwdata_pre", hwdata, 32'h55);
        reset = 1'b0;
        cyc();
        req_valid = 2'b10;
        #1 chk("mr_ready", req_ready, 2'b00);
        req_valid = '0;
        chk("mr_htrans", htrans, 0); chk("mr_haddr", haddr, 0); chk("mr_hwrite", hwrite, 0);
        chk("mr_hsize", hsize, 0); chk("mr_hprot", hprot, 0); chk("mr_hwdata", hwdata, 0);
        chk("mr_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
`ifdef AHB_MASTER_PERF_EN
        chk("mr_xfer_cnt", xfer_cnt, 0);
`endif
        reset = 1'b1;
        cyc(); chk("mr_norsp0", rsp_valid, 2'b00);
        cyc(); chk("mr_norsp1", rsp_valid, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
